pet_timing_gen: RTL and testbench

// - Master timing generator for the PET clone. Divides the 64 MHz system clock into a 64-cycle
//   (1 us) frame and produces pixel/character clock enables, 1 MHz CPU clock/bus-enable/strobe,

---
 rtl/pet_timing_gen.sv | 106 ++++++++++
 tb/tb_pet_timing_gen.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pet_timing_gen.sv
// Master 1 us frame timing generator: pixel/char enables, CPU PHI2/BE/strobe, video loads, slot grants.
// Optional macro TIMING_CPU_STALL_EN adds cpu_stall_i to hand whole frames to the WB master.
module pet_timing_gen #(
    parameter int SYS_CLOCK_MHZ = 64
) (
    input  logic       sys_clock_i,
    input  logic       sys_reset_n_i,
`ifdef TIMING_CPU_STALL_EN
    input  logic       cpu_stall_i,
`endif
    output logic       clk16_en_o,
    output logic       clk8_en_o,
    output logic       cpu_be_o,
    output logic       cpu_clock_o,
    output logic       cpu_data_strobe_o,
    output logic       load_sr1_o,
    output logic       load_sr2_o,
    output logic [1:0] grant_o,
    output logic       grant_valid_o
);

    localparam logic [1:0] GRANT_CPU   = 2'd0;
    localparam logic [1:0] GRANT_VIDEO = 2'd1;
    localparam logic [1:0] GRANT_WB    = 2'd2;

    generate
        if (SYS_CLOCK_MHZ != 64) begin : g_bad_clock
            $error("pet_timing_gen: SYS_CLOCK_MHZ must be 64");
        end
    endgenerate

    logic [5:0] c_reg;
    logic       stall_frame;

    logic       clk16_en_next;
    logic       clk8_en_next;
    logic       cpu_be_next;
    logic       cpu_clock_next;
    logic       cpu_data_strobe_next;
    logic       load_sr1_next;
    logic       load_sr2_next;
    logic [1:0] grant_next;
    logic       grant_valid_next;

`ifdef TIMING_CPU_STALL_EN
    logic stall_reg;

    // Stall request is latched on the last clock of a frame and governs the whole next frame.
    always_ff @(posedge sys_clock_i) begin
        if (!sys_reset_n_i) begin
            stall_reg <= 1'b0;
        end else if (c_reg == 6'd63) begin
            stall_reg <= cpu_stall_i;
        end
    end

    assign stall_frame = stall_reg;
`else
    assign stall_frame = 1'b0;
`endif

    always_comb begin
        clk16_en_next        = &c_reg[1:0];
        clk8_en_next         = &c_reg[2:0];
        cpu_be_next          = !stall_frame && (c_reg >= 6'd24);
        cpu_clock_next       = !stall_frame && c_reg[5];
        cpu_data_strobe_next = !stall_frame && (c_reg == 6'd62);
        load_sr1_next        = (c_reg == 6'd31);
        load_sr2_next        = (c_reg == 6'd63);
        grant_valid_next     = (c_reg[2:0] == 3'd0);
        grant_next           = GRANT_CPU;
        case (c_reg[5:3])
            3'd0, 3'd2: grant_next = GRANT_WB;
            3'd1, 3'd3: grant_next = GRANT_VIDEO;
            default:    grant_next = stall_frame ? GRANT_WB : GRANT_CPU;
        endcase
    end

    // Outputs lag the counter by one clock so every output is a plain flop.
    always_ff @(posedge sys_clock_i) begin
        if (!sys_reset_n_i) begin
            c_reg             <= 6'd0;
            clk16_en_o        <= 1'b0;
            clk8_en_o         <= 1'b0;
            cpu_be_o          <= 1'b0;
            cpu_clock_o       <= 1'b0;
            cpu_data_strobe_o <= 1'b0;
            load_sr1_o        <= 1'b0;
            load_sr2_o        <= 1'b0;
            grant_o           <= GRANT_CPU;
            grant_valid_o     <= 1'b0;
        end else begin
            c_reg             <= c_reg + 6'd1;
            clk16_en_o        <= clk16_en_next;
            clk8_en_o         <= clk8_en_next;
            cpu_be_o          <= cpu_be_next;
            cpu_clock_o       <= cpu_clock_next;
            cpu_data_strobe_o <= cpu_data_strobe_next;
            load_sr1_o        <= load_sr1_next;
            load_sr2_o        <= load_sr2_next;
            grant_o           <= grant_next;
            grant_valid_o     <= grant_valid_next;
        end
    end

endmodule

// File: tb/tb_pet_timing_gen.sv
// Randomized bench for pet_timing_gen against a frame-position reference model.
module tb_pet_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       clk16_en_o, clk8_en_o, cpu_be_o, cpu_clock_o, cpu_data_strobe_o;
    logic       load_sr1_o, load_sr2_o, grant_valid_o;
    logic [1:0] grant_o;
    logic [9:0] obs_vec;

    pet_timing_gen #(.SYS_CLOCK_MHZ(64)) dut (
        .sys_clock_i      (clk),
        .sys_reset_n_i    (rst_n),
`ifdef TIMING_CPU_STALL_EN
        .cpu_stall_i      (stall),
`endif
        .clk16_en_o       (clk16_en_o),
        .clk8_en_o        (clk8_en_o),
        .cpu_be_o         (cpu_be_o),
        .cpu_clock_o      (cpu_clock_o),
        .cpu_data_strobe_o(cpu_data_strobe_o),
        .load_sr1_o       (load_sr1_o),
        .load_sr2_o       (load_sr2_o),
        .grant_o          (grant_o),
        .grant_valid_o    (grant_valid_o)
    );

    always #5 clk = ~clk;

    assign obs_vec = {clk16_en_o, clk8_en_o, cpu_be_o, cpu_clock_o, cpu_data_strobe_o,
                      load_sr1_o, load_sr2_o, grant_o, grant_valid_o};

    int compared = 0;
    int mismatched = 0;

    // reference model state: frame position to be decoded next, and stall flag of current frame
    int m = 0;
    bit stall_m = 1'b0;
    int since_rel = 0;
    int n16, n8, nstb, ngv, nsr1, nsr2;
    bit track = 1'b0;
    int first_stb = 0;
    int first_gv = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output vector for frame position c, from the timing rules directly.
    function automatic logic [9:0] expect_at(input int c, input bit st);
        int slot_owner[8] = '{2, 1, 2, 1, 0, 0, 0, 0};
        int g;
        g = slot_owner[c / 8];
        if (st && c >= 32) g = 2;
        return {(c % 4 == 3), (c % 8 == 7), (!st && c >= 24), (!st && c >= 32),
                (!st && c == 62), (c == 31), (c == 63), g[1:0], (c % 8 == 0)};
    endfunction

    task automatic step(input bit r, input bit s);
        logic [9:0] exp_vec;
        int c_seen;
        rst_n = r;
        stall = s;
        @(posedge clk);
        c_seen = m;
        if (!r) begin
            exp_vec = '0;
            m = 0;
            stall_m = 1'b0;
            since_rel = 0;
        end else begin
            exp_vec = expect_at(m, stall_m);
`ifdef TIMING_CPU_STALL_EN
            if (m == 63) stall_m = s;
`endif
            m = (m + 1) % 64;
            since_rel++;
        end
        @(negedge clk);
        check($sformatf("cycle r=%0d c=%0d", r, c_seen), {22'd0, obs_vec}, {22'd0, exp_vec});
        n16  += int'(clk16_en_o);
        n8   += int'(clk8_en_o);
        nstb += int'(cpu_data_strobe_o);
        ngv  += int'(grant_valid_o);
        nsr1 += int'(load_sr1_o);
        nsr2 += int'(load_sr2_o);
        if (track && r) begin
            if (first_stb == 0 && cpu_data_strobe_o) first_stb = since_rel;
            if (first_gv == 0 && grant_valid_o) first_gv = since_rel;
        end
    endtask

    initial begin
        repeat (4) step(1'b0, 1'b0);

        // ten full frames from release
        n16 = 0; n8 = 0; nstb = 0; ngv = 0; nsr1 = 0; nsr2 = 0;
        repeat (640) step(1'b1, 1'b0);
        check("clk16_count", n16, 160);
        check("clk8_count", n8, 80);
        check("strobe_count", nstb, 10);
        check("gvalid_count", ngv, 80);
        check("load_sr1_count", nsr1, 10);
        check("load_sr2_count", nsr2, 10);

        // mid-frame reset at c=40 held 3 clocks
        for (int i = 0; i < 64 && m != 40; i++) step(1'b1, 1'b0);
        check("reached_c40", m, 40);
        repeat (3) step(1'b0, 1'b0);
        track = 1'b1;
        repeat (100) step(1'b1, 1'b0);
        track = 1'b0;
        check("rst_strobe_latency", first_stb, 63);
        check("rst_gvalid_latency", first_gv, 1);

        // random resets and stall requests
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
